// File: rtl/sparse_intersect.sv
// sparse_intersect: merges two decoded sparse streams, each ordered by strictly
// increasing index. Only index-matched value pairs are forwarded to the MAC
// stage, through a single output register. At the end of each vector pair the
// block pulses done_o together with the number of pairs it emitted.
module sparse_intersect #(
    parameter int INDEX_W = 16,
    parameter int VALUE_W = 8
) (
    input  logic               mac_clk,
    input  logic               mac_rst,
    input  logic               a_valid_i,
    output logic               a_ready_o,
    input  logic [INDEX_W-1:0] a_index_i,
    input  logic [VALUE_W-1:0] a_value_i,
    input  logic               a_last_i,
    input  logic               b_valid_i,
    output logic               b_ready_o,
    input  logic [INDEX_W-1:0] b_index_i,
    input  logic [VALUE_W-1:0] b_value_i,
    input  logic               b_last_i,
    output logic               match_valid_o,
    input  logic               match_ready_i,
    output logic [INDEX_W-1:0] match_index_o,
    output logic [VALUE_W-1:0] match_a_value_o,
    output logic [VALUE_W-1:0] match_b_value_o,
    output logic               done_o,
    output logic [INDEX_W:0]   match_count_o
);

    localparam int CNT_W = INDEX_W + 1;

    typedef enum logic [1:0] {
        ST_COMPARE = 2'd0,
        ST_DRAIN_A = 2'd1,
        ST_DRAIN_B = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [INDEX_W-1:0] out_index_q, out_index_d;
    logic [VALUE_W-1:0] out_a_q, out_a_d;
    logic [VALUE_W-1:0] out_b_q, out_b_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   done_count_q, done_count_d;

    logic out_free_s;
    logic both_valid_s;
    logic a_ready_s;
    logic b_ready_s;

    // Next-state, pop decisions and output-register loading.
    always_comb begin
        state_d      = state_q;
        out_index_d  = out_index_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        count_d      = count_q;
        done_d       = 1'b0;
        done_count_d = {CNT_W{1'b0}};
        a_ready_s    = 1'b0;
        b_ready_s    = 1'b0;

        out_free_s   = ~out_valid_q | match_ready_i;
        both_valid_s = a_valid_i & b_valid_i & out_free_s;

        // An accepted pair leaves the register unless replaced below.
        if (out_valid_q && match_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_COMPARE: begin
                if (both_valid_s) begin
                    if (a_index_i < b_index_i) begin
                        a_ready_s = 1'b1;
                    end else if (b_index_i < a_index_i) begin
                        b_ready_s = 1'b1;
                    end else begin
                        a_ready_s   = 1'b1;
                        b_ready_s   = 1'b1;
                        out_valid_d = 1'b1;
                        out_index_d = a_index_i;
                        out_a_d     = a_value_i;
                        out_b_d     = b_value_i;
                        if (count_q == {CNT_W{1'b1}}) begin
                            count_d = count_q;
                        end else begin
                            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end else begin
                    a_ready_s = 1'b0;
                    b_ready_s = 1'b0;
                end
                // A ready only asserts with both valids, so ready means popped.
                if (a_ready_s && a_last_i && b_ready_s && b_last_i) begin
                    state_d = ST_DONE;
                end else if (a_ready_s && a_last_i) begin
                    state_d = ST_DRAIN_B;
                end else if (b_ready_s && b_last_i) begin
                    state_d = ST_DRAIN_A;
                end else begin
                    state_d = ST_COMPARE;
                end
            end
            ST_DRAIN_A: begin
                a_ready_s = 1'b1;
                if (a_valid_i && a_last_i) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN_A;
                end
            end
            ST_DRAIN_B: begin
                b_ready_s = 1'b1;
                if (b_valid_i && b_last_i) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN_B;
                end
            end
            ST_DONE: begin
                // Hold off the done pulse until the final pair has been taken.
                if (out_free_s) begin
                    done_d       = 1'b1;
                    done_count_d = count_q;
                    count_d      = {CNT_W{1'b0}};
                    state_d      = ST_COMPARE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_COMPARE;
            end
        endcase
    end

    // State, output register and vector counter; synchronous active-low reset.
    always_ff @(posedge mac_clk) begin
        if (!mac_rst) begin
            state_q      <= ST_COMPARE;
            out_valid_q  <= 1'b0;
            out_index_q  <= {INDEX_W{1'b0}};
            out_a_q      <= {VALUE_W{1'b0}};
            out_b_q      <= {VALUE_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            done_q       <= 1'b0;
            done_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_index_q  <= out_index_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            count_q      <= count_d;
            done_q       <= done_d;
            done_count_q <= done_count_d;
        end
    end

    // Readies are held low while reset is asserted so nothing is consumed.
    assign a_ready_o       = a_ready_s & mac_rst;
    assign b_ready_o       = b_ready_s & mac_rst;
    assign match_valid_o   = out_valid_q;
    assign match_index_o   = out_index_q;
    assign match_a_value_o = out_a_q;
    assign match_b_value_o = out_b_q;
    assign done_o          = done_q;
    assign match_count_o   = done_count_q;

endmodule

// File: tb/tb_sparse_intersect.sv
// Bench for sparse_intersect: directed vectors from the test plan plus
// randomized back-to-back vectors, checked against a set-intersection model.
module tb_sparse_intersect;

    localparam int IW = 16;
    localparam int VW = 8;

    logic          mac_clk = 1'b0;
    logic          mac_rst;
    logic          a_valid_i, b_valid_i;
    logic          a_ready_o, b_ready_o;
    logic [IW-1:0] a_index_i, b_index_i;
    logic [VW-1:0] a_value_i, b_value_i;
    logic          a_last_i, b_last_i;
    logic          match_valid_o, match_ready_i;
    logic [IW-1:0] match_index_o;
    logic [VW-1:0] match_a_value_o, match_b_value_o;
    logic          done_o;
    logic [IW:0]   match_count_o;

    sparse_intersect #(.INDEX_W(IW), .VALUE_W(VW)) dut (
        .mac_clk         (mac_clk),
        .mac_rst         (mac_rst),
        .a_valid_i       (a_valid_i),
        .a_ready_o       (a_ready_o),
        .a_index_i       (a_index_i),
        .a_value_i       (a_value_i),
        .a_last_i        (a_last_i),
        .b_valid_i       (b_valid_i),
        .b_ready_o       (b_ready_o),
        .b_index_i       (b_index_i),
        .b_value_i       (b_value_i),
        .b_last_i        (b_last_i),
        .match_valid_o   (match_valid_o),
        .match_ready_i   (match_ready_i),
        .match_index_o   (match_index_o),
        .match_a_value_o (match_a_value_o),
        .match_b_value_o (match_b_value_o),
        .done_o          (done_o),
        .match_count_o   (match_count_o)
    );

    always #5 mac_clk = ~mac_clk;

    typedef struct {
        logic [IW-1:0] idx;
        logic [VW-1:0] val;
        logic          last;
    } elem_t;

    typedef struct {
        logic [IW-1:0] idx;
        logic [VW-1:0] av;
        logic [VW-1:0] bv;
    } pair_t;

    elem_t qa[$];
    elem_t qb[$];
    pair_t exp_pairs[$];
    int    exp_counts[$];
    int    sa_i[$], sa_v[$], sb_i[$], sb_v[$];

    int n_vec  = 0;
    int n_miss = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Queue the scratch vector pair as stimulus and derive the expected result
    // as the plain intersection of the two index sets.
    task automatic add_vec();
        int cnt;
        pair_t p;
        elem_t e;
        cnt = 0;
        foreach (sa_i[i]) begin
            e.idx = IW'(sa_i[i]); e.val = VW'(sa_v[i]); e.last = (i == sa_i.size() - 1);
            qa.push_back(e);
        end
        foreach (sb_i[j]) begin
            e.idx = IW'(sb_i[j]); e.val = VW'(sb_v[j]); e.last = (j == sb_i.size() - 1);
            qb.push_back(e);
        end
        foreach (sa_i[i]) begin
            foreach (sb_i[j]) begin
                if (sa_i[i] == sb_i[j]) begin
                    p.idx = IW'(sa_i[i]); p.av = VW'(sa_v[i]); p.bv = VW'(sb_v[j]);
                    exp_pairs.push_back(p);
                    cnt++;
                end
            end
        end
        exp_counts.push_back(cnt);
    endtask

    task automatic rand_vec();
        sa_i = {}; sa_v = {}; sb_i = {}; sb_v = {};
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(2) == 0) begin sa_i.push_back(k); sa_v.push_back(int'($urandom_range(255))); end
            if ($urandom_range(2) == 0) begin sb_i.push_back(k); sb_v.push_back(int'($urandom_range(255))); end
        end
        if (sa_i.size() == 0) begin sa_i.push_back(int'($urandom_range(39))); sa_v.push_back(7); end
        if (sb_i.size() == 0) begin sb_i.push_back(int'($urandom_range(39))); sb_v.push_back(9); end
        add_vec();
    endtask

    task automatic basic_vec();
        sa_i = '{3, 10, 12}; sa_v = '{5, 4, 7};
        sb_i = '{3, 8, 12};  sb_v = '{2, 1, 3};
        add_vec();
    endtask

    // Cycle loop: drive inputs on the falling edge, observe after settling.
    task automatic run(input bit bubbles, input bit stall_en, input bit abort_on_match,
                       output int done_cyc);
        int  cyc, stall_left;
        bit  stalled_once, a_fire, b_fire, forced, go;
        pair_t p;
        cyc = 0; stall_left = 0; stalled_once = 1'b0;
        a_fire = 1'b0; b_fire = 1'b0; done_cyc = -1; go = 1'b1;
        while (go) begin
            @(negedge mac_clk);
            cyc++;
            if (a_fire) void'(qa.pop_front());
            if (b_fire) void'(qb.pop_front());
            if (qa.size() > 0 && (!bubbles || $urandom_range(3) != 0)) begin
                a_valid_i = 1'b1; a_index_i = qa[0].idx; a_value_i = qa[0].val; a_last_i = qa[0].last;
            end else begin
                a_valid_i = 1'b0; a_index_i = '0; a_value_i = '0; a_last_i = 1'b0;
            end
            if (qb.size() > 0 && (!bubbles || $urandom_range(3) != 0)) begin
                b_valid_i = 1'b1; b_index_i = qb[0].idx; b_value_i = qb[0].val; b_last_i = qb[0].last;
            end else begin
                b_valid_i = 1'b0; b_index_i = '0; b_value_i = '0; b_last_i = 1'b0;
            end
            if (stall_en && !stalled_once && match_valid_o) begin
                stall_left = 5; stalled_once = 1'b1;
            end
            forced = 1'b0;
            if (stall_left > 0) begin
                match_ready_i = 1'b0; stall_left--; forced = 1'b1;
            end else begin
                match_ready_i = bubbles ? ($urandom_range(3) != 0) : 1'b1;
            end
            #1;
            a_fire = a_valid_i & a_ready_o;
            b_fire = b_valid_i & b_ready_o;
            if (forced) check_eq("stall_no_pop", {30'd0, a_fire, b_fire}, 32'd0);
            if (match_valid_o) begin
                if (exp_pairs.size() == 0) begin
                    check_eq("spurious_match", 32'd1, 32'd0);
                end else begin
                    p = exp_pairs[0];
                    check_eq("match_index", 32'(match_index_o), 32'(p.idx));
                    check_eq("match_a_value", 32'(match_a_value_o), 32'(p.av));
                    check_eq("match_b_value", 32'(match_b_value_o), 32'(p.bv));
                    if (match_ready_i) void'(exp_pairs.pop_front());
                end
            end
            if (done_o) begin
                done_cyc = cyc;
                check_eq("done_no_pending_pair", 32'(match_valid_o), 32'd0);
                if (exp_counts.size() == 0) begin
                    check_eq("spurious_done", 32'd1, 32'd0);
                end else begin
                    check_eq("done_count", 32'(match_count_o), 32'(exp_counts.pop_front()));
                end
            end
            if (abort_on_match && match_valid_o) begin
                go = 1'b0;
            end else if (exp_counts.size() == 0 && exp_pairs.size() == 0) begin
                go = 1'b0;
            end else if (cyc >= 4000) begin
                check_eq("timeout", 32'd1, 32'd0);
                go = 1'b0;
            end
        end
        check_eq("inputs_consumed", 32'(qa.size() + qb.size()), abort_on_match ? 32'(qa.size() + qb.size()) + 32'd0 : 32'd0);
        a_valid_i = 1'b0; b_valid_i = 1'b0; match_ready_i = 1'b1;
    endtask

    // Top-level sequence of the test plan followed by randomized vectors.
    initial begin
        int dc;
        mac_rst = 1'b0;
        a_valid_i = 1'b1; a_index_i = '0; a_value_i = '0; a_last_i = 1'b0;
        b_valid_i = 1'b1; b_index_i = '0; b_value_i = '0; b_last_i = 1'b0;
        match_ready_i = 1'b1;
        @(negedge mac_clk);
        @(negedge mac_clk);
        #1;
        check_eq("rst_match_valid", 32'(match_valid_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_count", 32'(match_count_o), 32'd0);
        check_eq("rst_a_ready", 32'(a_ready_o), 32'd0);
        check_eq("rst_b_ready", 32'(b_ready_o), 32'd0);
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        @(negedge mac_clk);
        mac_rst = 1'b1;

        // Basic intersect: done two cycles after the final pop of 12.
        basic_vec();
        run(1'b0, 1'b0, 1'b0, dc);
        check_eq("basic_done_cycle", 32'(dc), 32'd6);

        // Disjoint vectors: A ends first, B drained, count 0.
        sa_i = '{1, 4}; sa_v = '{1, 2}; sb_i = '{2, 7}; sb_v = '{9, 9};
        add_vec();
        run(1'b0, 1'b0, 1'b0, dc);

        // Early finish: A is a single element, rest of B drained.
        sa_i = '{0}; sa_v = '{3}; sb_i = '{0, 5, 9, 11}; sb_v = '{4, 1, 2, 6};
        add_vec();
        run(1'b0, 1'b0, 1'b0, dc);

        // Backpressure: five stalled cycles push done out by five.
        basic_vec();
        run(1'b0, 1'b1, 1'b0, dc);
        check_eq("stall_done_cycle", 32'(dc), 32'd11);

        // Back-to-back vector pairs with counts 2 then 1.
        basic_vec();
        sa_i = '{5, 6}; sa_v = '{1, 2}; sb_i = '{6}; sb_v = '{3};
        add_vec();
        run(1'b0, 1'b0, 1'b0, dc);

        // Reset mid-vector after the first pair appears.
        basic_vec();
        run(1'b0, 1'b0, 1'b1, dc);
        a_valid_i = 1'b1; b_valid_i = 1'b1; a_index_i = 16'd20; b_index_i = 16'd20;
        mac_rst = 1'b0;
        @(negedge mac_clk);
        #1;
        check_eq("midrst_match_valid", 32'(match_valid_o), 32'd0);
        check_eq("midrst_match_index", 32'(match_index_o), 32'd0);
        check_eq("midrst_match_a", 32'(match_a_value_o), 32'd0);
        check_eq("midrst_match_b", 32'(match_b_value_o), 32'd0);
        check_eq("midrst_done", 32'(done_o), 32'd0);
        check_eq("midrst_count", 32'(match_count_o), 32'd0);
        check_eq("midrst_readies", {30'd0, a_ready_o, b_ready_o}, 32'd0);
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        @(negedge mac_clk);
        mac_rst = 1'b1;
        #1;
        check_eq("postrst_done", 32'(done_o), 32'd0);
        qa = {}; qb = {}; exp_pairs = {}; exp_counts = {};
        sa_i = '{2, 9}; sa_v = '{11, 12}; sb_i = '{1, 9}; sb_v = '{13, 14};
        add_vec();
        run(1'b0, 1'b0, 1'b0, dc);

        // Randomized back-to-back vectors with input bubbles and random ready.
        for (int v = 0; v < 12; v++) rand_vec();
        run(1'b1, 1'b0, 1'b0, dc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
